// File: rtl/refresh_pkg.sv
// Shared types and defaults for the gain-cell DRAM refresh scoreboard.
package refresh_pkg;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_SWEEP,
        RS_RETAIN
    } ref_state_e;

    localparam int REF_ROWS_DEF      = 128;
    localparam int REF_RETENTION_DEF = 3000;

endpackage

// File: rtl/refresh_scoreboard_timer.sv
// Retention counter: counts while enabled, pulses expire on the last cycle.
module retention_timer #(
    parameter int RETENTION = 3000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(RETENTION + 1);
    localparam logic [CW-1:0] LAST = CW'(RETENTION - 1);

    logic [CW-1:0] r_cnt;

    assign expire = enable && !clear && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/refresh_scoreboard.sv
// Per-row freshness tracker with background/demand refresh sweep.
// Optional REF_SKIP_FRESH_EN: skip already-fresh rows during the sweep.
module refresh_scoreboard
    import refresh_pkg::*;
#(
    parameter int ROWS       = REF_ROWS_DEF,
    parameter int ADDR_W     = $clog2(ROWS),
    parameter int RETENTION  = REF_RETENTION_DEF,
    parameter int AUTO_START = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_fresh,
    output logic              ref_valid,
    output logic [ADDR_W-1:0] ref_addr,
    input  logic              ref_ready,
    output logic              busy,
    output logic              done,
    output logic              expired
);

    localparam logic [ADDR_W:0]   ROWS_L = ROWS[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(ROWS - 1);

    ref_state_e        r_state, w_state_n;
    logic [ROWS-1:0]   r_fresh, w_fresh_n;
    logic [ADDR_W-1:0] r_ptr, w_ptr_n;
    logic              r_expired, w_exp_n;
    logic              w_rd_in, w_wr_in, w_demand, w_bg, w_expire;

    assign w_rd_in  = {1'b0, rd_addr} < ROWS_L;
    assign w_wr_in  = {1'b0, wr_addr} < ROWS_L;
    assign rd_fresh = w_rd_in && r_fresh[rd_addr];
    assign w_demand = (r_state == RS_SWEEP) && rd_en && w_rd_in
                      && !r_fresh[rd_addr];
    assign busy     = (r_state == RS_SWEEP);
    assign done     = !busy;
    assign expired  = r_expired;

    retention_timer #(.RETENTION(RETENTION)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  ((r_state != RS_RETAIN) || start),
        .enable (r_state == RS_RETAIN),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= RS_IDLE;
            r_fresh   <= '0;
            r_ptr     <= '0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_fresh   <= w_fresh_n;
            r_ptr     <= w_ptr_n;
            r_expired <= w_exp_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_fresh_n = r_fresh;
        w_ptr_n   = r_ptr;
        w_exp_n   = 1'b0;
        w_bg      = 1'b0;
        ref_valid = 1'b0;
        ref_addr  = r_ptr;
        unique case (r_state)
            RS_IDLE: begin
                if (start) begin
                    w_state_n = RS_SWEEP;
                    w_fresh_n = '0;
                    w_ptr_n   = '0;
                end
            end
            RS_SWEEP: begin
                if (w_demand) begin
                    ref_valid = 1'b1;
                    ref_addr  = rd_addr;
                    if (ref_ready) w_fresh_n[rd_addr] = 1'b1;
                end else begin
`ifdef REF_SKIP_FRESH_EN
                    ref_valid = !r_fresh[r_ptr];
                    w_bg      = r_fresh[r_ptr] || ref_ready;
`else
                    ref_valid = 1'b1;
                    w_bg      = ref_ready;
`endif
                    if (ref_valid && ref_ready) w_fresh_n[r_ptr] = 1'b1;
                    if (w_bg) begin
                        if (r_ptr == LAST) w_state_n = RS_RETAIN;
                        else               w_ptr_n   = r_ptr + 1'b1;
                    end
                end
            end
            RS_RETAIN: begin
                if (start) begin
                    w_state_n = RS_SWEEP;
                    w_fresh_n = '0;
                    w_ptr_n   = '0;
                end else if (w_expire) begin
                    w_fresh_n = '0;
                    w_ptr_n   = '0;
                    w_exp_n   = 1'b1;
                    w_state_n = (AUTO_START != 0) ? RS_SWEEP : RS_IDLE;
                end
            end
            default: w_state_n = RS_IDLE;
        endcase
        // A write on the same cycle as a clear keeps its row fresh.
        if (wr_en && w_wr_in) w_fresh_n[wr_addr] = 1'b1;
    end

endmodule

// File: tb/tb_refresh_scoreboard.sv
// Directed bench for refresh_scoreboard (ROWS=128, RETENTION=20).
module tb_refresh_scoreboard;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n, start, wr_en, rd_en, ref_ready;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          rd_fresh, ref_valid, busy, done, expired;
    logic [AW-1:0] ref_addr;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    refresh_scoreboard #(
        .ROWS(128), .RETENTION(20), .AUTO_START(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_fresh(rd_fresh),
        .ref_valid(ref_valid), .ref_addr(ref_addr),
        .ref_ready(ref_ready),
        .busy(busy), .done(done), .expired(expired)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rdchk(input string tag, input int a, input int exp);
        rd_addr = AW'(a);
        #1;
        chk(tag, int'(rd_fresh), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad, cyc, acc, s90;
        rst_n = 0; start = 0; wr_en = 0; rd_en = 0; ref_ready = 0;
        wr_addr = '0; rd_addr = '0;
        step(); step();
        rst_n = 1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 1);
        chk("rst_valid", int'(ref_valid), 0);
        chk("rst_exp", int'(expired), 0);
        rdchk("rst_fresh0", 0, 0);

        // Full background sweep
        start = 1;
        step();
        start = 0;
        ref_ready = 1;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (ref_valid !== 1'b1 || ref_addr !== AW'(i) || busy !== 1'b1)
                bad++;
            step();
        end
        chk("sweep_seq", bad, 0);
        chk("sweep_done", int'(done), 1);
        rdchk("sweep_f0", 0, 1);
        rdchk("sweep_f127", 127, 1);

        // Retention expiry with auto restart
        bad = 0;
        for (int k = 1; k < 20; k++) begin
            step();
            if (expired !== 1'b0) bad++;
        end
        chk("ret_early", bad, 0);
        step();
        chk("ret_exp", int'(expired), 1);
        chk("ret_busy", int'(busy), 1);
        chk("ret_addr0", int'(ref_addr), 0);
        ref_ready = 0;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            rd_addr = AW'(i);
            #1;
            if (rd_fresh !== 1'b0) bad++;
        end
        chk("ret_cleared", bad, 0);
        chk("ret_pulse1", int'(expired), 0);

        // Stall at row 3
        ref_ready = 1;
        step(); step(); step();
        ref_ready = 0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (ref_valid !== 1'b1 || ref_addr !== AW'(3)) bad++;
            step();
        end
        chk("stall_hold", bad, 0);
        rdchk("stall_f3", 3, 0);
        ref_ready = 1;
        step();
        chk("stall_ptr4", int'(ref_addr), 4);
        rdchk("stall_f3b", 3, 1);

        // Demand refresh at ptr 10
        repeat (6) step();
        chk("dem_ptr10", int'(ref_addr), 10);
        rd_en = 1; rd_addr = 90;
        #1;
        chk("dem_addr", int'(ref_addr), 90);
        chk("dem_valid", int'(ref_valid), 1);
        step();
        rd_en = 0;
        #1;
        chk("dem_back", int'(ref_addr), 10);
        rdchk("dem_f90", 90, 1);

        // User write ahead of the pointer
        wr_en = 1; wr_addr = 50;
        step();
        wr_en = 0;
        rdchk("wr_f50", 50, 1);
        cyc = 0; acc = 0; s90 = 0;
        while (busy && cyc < 500) begin
            if (ref_valid) begin
                acc++;
                if (ref_addr == AW'(90)) s90 = 1;
            end
            step();
            cyc++;
        end
        chk("tail_timeout", int'(busy), 0);
        chk("tail_cycles", cyc, 117);
`ifdef REF_SKIP_FRESH_EN
        chk("tail_accepts", acc, 115);
        chk("tail_row90", s90, 0);
`else
        chk("tail_accepts", acc, 117);
        chk("tail_row90", s90, 1);
`endif

        // Start in RETAIN with a simultaneous write
        ref_ready = 0;
        step(); step(); step();
        chk("rt_done", int'(done), 1);
        start = 1; wr_en = 1; wr_addr = 5;
        step();
        start = 0; wr_en = 0;
        chk("rt_busy", int'(busy), 1);
        chk("rt_addr0", int'(ref_addr), 0);
        chk("rt_noexp", int'(expired), 0);
        rdchk("rt_f5", 5, 1);
        rdchk("rt_f6", 6, 0);
        rdchk("rt_f90", 90, 0);

        // Reset mid-sweep at ptr 64
        ref_ready = 1;
        repeat (64) step();
        chk("mid_ptr64", int'(ref_addr), 64);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("mid_done", int'(done), 1);
        chk("mid_busy", int'(busy), 0);
        chk("mid_valid", int'(ref_valid), 0);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            rd_addr = AW'(i);
            #1;
            if (rd_fresh !== 1'b0) bad++;
        end
        chk("mid_cleared", bad, 0);
        step();
        chk("mid_valid2", int'(ref_valid), 0);
        start = 1;
        step();
        start = 0;
        chk("mid_restart", int'(ref_addr), 0);
        chk("mid_rbusy", int'(busy), 1);
        step();
        chk("mid_next", int'(ref_addr), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
